// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, ALU op codes and pipeline control record for the 8-bit core
package core_pkg;

    localparam int DATA_W = 8;
    localparam int REG_AW = 3;

    localparam logic ALU_OP_MOV = 1'b0;
    localparam logic ALU_OP_ADD = 1'b1;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_AW-1:0] rd;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t PIPE_BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - priority operand select: r0, EX/MEM, MEM/WB, then the captured register-file value
module fwd_mux
    import core_pkg::*;
#(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int REG_AW = core_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] id_data,
    input  pipe_ctrl_t        ex_mem_ctrl,
    input  logic [DATA_W-1:0] ex_mem_data,
    input  pipe_ctrl_t        mem_wb_ctrl,
    input  logic [DATA_W-1:0] mem_wb_data,
    output logic [DATA_W-1:0] data
);

    logic hit_ex_mem;
    logic hit_mem_wb;

    assign hit_ex_mem = ex_mem_ctrl.valid && ex_mem_ctrl.reg_write && (ex_mem_ctrl.rd == src);
    assign hit_mem_wb = mem_wb_ctrl.valid && mem_wb_ctrl.reg_write && (mem_wb_ctrl.rd == src);

    // The youngest producer wins so a later write to the same register shadows an older one.
    always_comb begin
        data = id_data;
        if (src == '0) begin
            data = '0;
        end else if (hit_ex_mem) begin
            data = ex_mem_data;
        end else if (hit_mem_wb) begin
            data = mem_wb_data;
        end
    end

endmodule

// File: rtl/operand_forward_stage.sv
// rtl/operand_forward_stage.sv - ID/EX, EX/MEM, MEM/WB registers with EX operand forwarding (option: WB_BYPASS_EN)
module operand_forward_stage
    import core_pkg::*;
#(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int REG_AW = core_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_alu_op,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [DATA_W-1:0] id_data2,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] Data1_Final,
    output logic [DATA_W-1:0] Data2_Final,
    output logic              ALU_Op,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    pipe_ctrl_t        id_ex_ctrl;
    logic              id_ex_op;
    logic [REG_AW-1:0] id_ex_rs1;
    logic [REG_AW-1:0] id_ex_rs2;
    logic [DATA_W-1:0] id_ex_data1;
    logic [DATA_W-1:0] id_ex_data2;

    pipe_ctrl_t        ex_mem_ctrl;
    logic [DATA_W-1:0] ex_mem_data;

    pipe_ctrl_t        mem_wb_ctrl;
    logic [DATA_W-1:0] mem_wb_data;

    logic [DATA_W-1:0] cap_data1;
    logic [DATA_W-1:0] cap_data2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;

`ifdef WB_BYPASS_EN
    // A producer three ahead writes in the same cycle ID reads, so take the write value directly.
    assign cap_data1 = (wb_en && (wb_rd == id_rs1) && (id_rs1 != '0)) ? wb_data : id_data1;
    assign cap_data2 = (wb_en && (wb_rd == id_rs2) && (id_rs2 != '0)) ? wb_data : id_data2;
`else
    assign cap_data1 = id_data1;
    assign cap_data2 = id_data2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_ctrl  <= PIPE_BUBBLE;
            id_ex_op    <= ALU_OP_MOV;
            id_ex_rs1   <= '0;
            id_ex_rs2   <= '0;
            id_ex_data1 <= '0;
            id_ex_data2 <= '0;
        end else if (flush) begin
            id_ex_ctrl <= PIPE_BUBBLE;
            id_ex_op   <= ALU_OP_MOV;
        end else if (!stall) begin
            id_ex_ctrl.valid     <= id_valid;
            id_ex_ctrl.reg_write <= id_valid & id_reg_write;
            id_ex_ctrl.rd        <= id_rd;
            id_ex_op             <= id_valid & id_alu_op;
            id_ex_rs1            <= id_rs1;
            id_ex_rs2            <= id_rs2;
            id_ex_data1          <= cap_data1;
            id_ex_data2          <= cap_data2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_ctrl <= PIPE_BUBBLE;
            ex_mem_data <= '0;
        end else if (stall) begin
            ex_mem_ctrl <= PIPE_BUBBLE;
            ex_mem_data <= '0;
        end else begin
            ex_mem_ctrl <= id_ex_ctrl;
            ex_mem_data <= alu_result;
        end
    end

    // No memory access in this core: MEM/WB is a plain copy of EX/MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_ctrl <= PIPE_BUBBLE;
            mem_wb_data <= '0;
        end else begin
            mem_wb_ctrl <= ex_mem_ctrl;
            mem_wb_data <= ex_mem_data;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
        .src         (id_ex_rs1),
        .id_data     (id_ex_data1),
        .ex_mem_ctrl (ex_mem_ctrl),
        .ex_mem_data (ex_mem_data),
        .mem_wb_ctrl (mem_wb_ctrl),
        .mem_wb_data (mem_wb_data),
        .data        (fwd_data1)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
        .src         (id_ex_rs2),
        .id_data     (id_ex_data2),
        .ex_mem_ctrl (ex_mem_ctrl),
        .ex_mem_data (ex_mem_data),
        .mem_wb_ctrl (mem_wb_ctrl),
        .mem_wb_data (mem_wb_data),
        .data        (fwd_data2)
    );

    assign Data1_Final = id_ex_ctrl.valid ? fwd_data1 : '0;
    assign Data2_Final = id_ex_ctrl.valid ? fwd_data2 : '0;
    assign ALU_Op      = id_ex_op & id_ex_ctrl.valid;

    assign wb_en   = mem_wb_ctrl.valid & mem_wb_ctrl.reg_write & (mem_wb_ctrl.rd != '0);
    assign wb_rd   = mem_wb_ctrl.rd;
    assign wb_data = mem_wb_data;

endmodule

// File: tb/tb_operand_forward_stage.sv
// tb/tb_operand_forward_stage.sv - vector table plus scoreboard bench for operand_forward_stage
module tb_operand_forward_stage;
    import core_pkg::*;

    typedef struct packed {
        logic       valid;
        logic       op;
        logic       rw;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
        logic [7:0] d1;
        logic [7:0] d2;
    } ins_t;

    typedef struct packed {
        logic       en;
        logic [2:0] rd;
        logic [7:0] data;
    } wb_t;

    typedef struct {
        ins_t       i;
        logic [7:0] e_d1;
        logic [7:0] e_d2;
        logic       e_op;
        wb_t        w;
    } vec_t;

`ifdef WB_BYPASS_EN
    localparam logic [7:0] BYP_V = 8'h05;
    localparam logic [7:0] BYP_W = 8'h0A;
`else
    localparam logic [7:0] BYP_V = 8'h00;
    localparam logic [7:0] BYP_W = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall, flush;
    logic       id_valid, id_alu_op, id_reg_write;
    logic [2:0] id_rs1, id_rs2, id_rd;
    logic [7:0] id_data1, id_data2;
    logic [7:0] alu_result;
    logic [7:0] Data1_Final, Data2_Final;
    logic       ALU_Op;
    logic       wb_en;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;

    int checks   = 0;
    int failures = 0;

    wb_t  sbq[$];
    vec_t tbl[13];

    always #5 clk = ~clk;

    // Behavioural ALU: add or pass operand 1.
    assign alu_result = ALU_Op ? 8'(Data1_Final + Data2_Final) : Data1_Final;

    operand_forward_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_alu_op    (id_alu_op),
        .id_reg_write (id_reg_write),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_data1     (id_data1),
        .id_data2     (id_data2),
        .alu_result   (alu_result),
        .Data1_Final  (Data1_Final),
        .Data2_Final  (Data2_Final),
        .ALU_Op       (ALU_Op),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    function automatic ins_t mk(input logic v, input logic op, input logic rw,
                                input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                                input logic [7:0] d1, input logic [7:0] d2);
        ins_t r;
        r.valid = v; r.op = op; r.rw = rw;
        r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.d1 = d1; r.d2 = d2;
        return r;
    endfunction

    function automatic wb_t wbx(input logic en, input logic [2:0] rd, input logic [7:0] data);
        wb_t w;
        w.en = en; w.rd = rd; w.data = data;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " d1"},     32'(Data1_Final), 32'h0);
        chk({tag, " d2"},     32'(Data2_Final), 32'h0);
        chk({tag, " aluop"},  32'(ALU_Op),      32'h0);
        chk({tag, " wb_en"},  32'(wb_en),       32'h0);
        chk({tag, " wb_rd"},  32'(wb_rd),       32'h0);
        chk({tag, " wb_dat"}, 32'(wb_data),     32'h0);
    endtask

    task automatic drive(input ins_t i, input logic st, input logic fl);
        id_valid = i.valid; id_alu_op = i.op; id_reg_write = i.rw;
        id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
        id_data1 = i.d1; id_data2 = i.d2;
        stall = st; flush = fl;
    endtask

    // Pipeline starts empty: the first two writeback slots are bubbles.
    task automatic sb_restart();
        sbq.delete();
        sbq.push_back(wbx(1'b0, 3'd0, 8'h00));
        sbq.push_back(wbx(1'b0, 3'd0, 8'h00));
    endtask

    task automatic step(input string tag, input ins_t i, input logic st, input logic fl,
                        input logic [7:0] e1, input logic [7:0] e2, input logic eop, input wb_t push);
        wb_t exp;
        @(negedge clk);
        drive(i, st, fl);
        sbq.push_back(push);
        @(posedge clk);
        #1;
        chk({tag, " d1"},    32'(Data1_Final), 32'(e1));
        chk({tag, " d2"},    32'(Data2_Final), 32'(e2));
        chk({tag, " aluop"}, 32'(ALU_Op),      32'(eop));
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty actual=0 required=1", tag);
        end else begin
            exp = sbq.pop_front();
            chk({tag, " wb_en"}, 32'(wb_en), 32'(exp.en));
            if (exp.en) begin
                chk({tag, " wb_rd"},  32'(wb_rd),   32'(exp.rd));
                chk({tag, " wb_dat"}, 32'(wb_data), 32'(exp.data));
            end
        end
    endtask

    ins_t NOP;
    wb_t  WB0;

    initial begin
        NOP = mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00);
        WB0 = wbx(1'b0, 3'd0, 8'h00);

        // mov r1=5; add r2=r1+r1 (EX/MEM fwd); mov r3=0x20; nop; add r4=r3+r3 (MEM/WB fwd)
        tbl[0]  = '{mk(1'b1, 1'b0, 1'b1, 3'd6, 3'd0, 3'd1, 8'h05, 8'h00), 8'h05, 8'h00, 1'b0, wbx(1'b1, 3'd1, 8'h05)};
        tbl[1]  = '{mk(1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 3'd2, 8'h00, 8'h00), 8'h05, 8'h05, 1'b1, wbx(1'b1, 3'd2, 8'h0A)};
        tbl[2]  = '{mk(1'b1, 1'b0, 1'b1, 3'd6, 3'd0, 3'd3, 8'h20, 8'h00), 8'h20, 8'h00, 1'b0, wbx(1'b1, 3'd3, 8'h20)};
        tbl[3]  = '{mk(1'b0, 1'b1, 1'b1, 3'd6, 3'd6, 3'd5, 8'h77, 8'h77), 8'h00, 8'h00, 1'b0, wbx(1'b0, 3'd0, 8'h00)};
        tbl[4]  = '{mk(1'b1, 1'b1, 1'b1, 3'd3, 3'd3, 3'd4, 8'h00, 8'h00), 8'h20, 8'h20, 1'b1, wbx(1'b1, 3'd4, 8'h40)};
        // mov r1=0x11; mov r1=0x22; add r5=r1+r0 (youngest wins, r0 reads zero)
        tbl[5]  = '{mk(1'b1, 1'b0, 1'b1, 3'd6, 3'd0, 3'd1, 8'h11, 8'h00), 8'h11, 8'h00, 1'b0, wbx(1'b1, 3'd1, 8'h11)};
        tbl[6]  = '{mk(1'b1, 1'b0, 1'b1, 3'd6, 3'd0, 3'd1, 8'h22, 8'h00), 8'h22, 8'h00, 1'b0, wbx(1'b1, 3'd1, 8'h22)};
        tbl[7]  = '{mk(1'b1, 1'b1, 1'b1, 3'd1, 3'd0, 3'd5, 8'h33, 8'h44), 8'h22, 8'h00, 1'b1, wbx(1'b1, 3'd5, 8'h22)};
        // write to r0 is dropped and never forwarded
        tbl[8]  = '{mk(1'b1, 1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 8'hFF, 8'h00), 8'hFF, 8'h00, 1'b0, wbx(1'b0, 3'd0, 8'h00)};
        tbl[9]  = '{mk(1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 3'd2, 8'h55, 8'h66), 8'h00, 8'h00, 1'b1, wbx(1'b1, 3'd2, 8'h00)};
        tbl[10] = '{mk(1'b1, 1'b1, 1'b1, 3'd6, 3'd7, 3'd6, 8'h10, 8'h01), 8'h10, 8'h01, 1'b1, wbx(1'b1, 3'd6, 8'h11)};
        // non-writing instruction to r6 must not shadow the older writer
        tbl[11] = '{mk(1'b1, 1'b0, 1'b0, 3'd7, 3'd0, 3'd6, 8'h99, 8'h00), 8'h99, 8'h00, 1'b0, wbx(1'b0, 3'd0, 8'h00)};
        tbl[12] = '{mk(1'b1, 1'b1, 1'b1, 3'd6, 3'd7, 3'd3, 8'h10, 8'h01), 8'h11, 8'h01, 1'b1, wbx(1'b1, 3'd3, 8'h12)};

        rst_n = 1'b0;
        drive(NOP, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        sb_restart();

        for (int k = 0; k < 13; k++)
            step($sformatf("vec%0d", k), tbl[k].i, 1'b0, 1'b0, tbl[k].e_d1, tbl[k].e_d2, tbl[k].e_op, tbl[k].w);
        step("drain0", NOP, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, WB0);
        step("drain1", NOP, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, WB0);

        // add r4=r6+r7 held by a two-cycle stall; stalled ID instruction must not enter
        step("stl0", mk(1'b1, 1'b1, 1'b1, 3'd6, 3'd7, 3'd4, 8'h03, 8'h04), 1'b0, 1'b0, 8'h03, 8'h04, 1'b1, WB0);
        step("stl1", mk(1'b1, 1'b1, 1'b1, 3'd6, 3'd6, 3'd6, 8'h0F, 8'h0F), 1'b1, 1'b0, 8'h03, 8'h04, 1'b1, WB0);
        step("stl2", mk(1'b1, 1'b1, 1'b1, 3'd6, 3'd6, 3'd6, 8'h0F, 8'h0F), 1'b1, 1'b0, 8'h03, 8'h04, 1'b1, wbx(1'b1, 3'd4, 8'h07));
        step("stl3", NOP, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, WB0);
        step("flst", mk(1'b1, 1'b0, 1'b1, 3'd6, 3'd0, 3'd5, 8'h09, 8'h00), 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, WB0);
        step("fl",   mk(1'b1, 1'b0, 1'b1, 3'd6, 3'd0, 3'd5, 8'h09, 8'h00), 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, WB0);
        step("stl4", NOP, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, WB0);
        step("stl5", NOP, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, WB0);

        // producer three ahead: writeback coincides with the ID read of a stale register file
        step("byp0", mk(1'b1, 1'b0, 1'b1, 3'd6, 3'd0, 3'd1, 8'h05, 8'h00), 1'b0, 1'b0, 8'h05, 8'h00, 1'b0, wbx(1'b1, 3'd1, 8'h05));
        step("byp1", NOP, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, WB0);
        step("byp2", NOP, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, WB0);
        step("byp3", mk(1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 3'd2, 8'h00, 8'h00), 1'b0, 1'b0, BYP_V, BYP_V, 1'b1, wbx(1'b1, 3'd2, BYP_W));
        step("byp4", NOP, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, WB0);
        step("byp5", NOP, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, WB0);

        // three writers in flight, then asynchronous reset mid-cycle
        step("rs0", mk(1'b1, 1'b0, 1'b1, 3'd6, 3'd0, 3'd1, 8'h01, 8'h00), 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, wbx(1'b1, 3'd1, 8'h01));
        step("rs1", mk(1'b1, 1'b0, 1'b1, 3'd7, 3'd0, 3'd2, 8'h02, 8'h00), 1'b0, 1'b0, 8'h02, 8'h00, 1'b0, wbx(1'b1, 3'd2, 8'h02));
        step("rs2", mk(1'b1, 1'b0, 1'b1, 3'd6, 3'd0, 3'd3, 8'h03, 8'h00), 1'b0, 1'b0, 8'h03, 8'h00, 1'b0, wbx(1'b1, 3'd3, 8'h03));
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(posedge clk);
        #1;
        chk_all_zero("rst_held");
        @(negedge clk);
        drive(NOP, 1'b0, 1'b0);
        rst_n = 1'b1;
        sb_restart();
        for (int k = 0; k < 4; k++)
            step($sformatf("post%0d", k), NOP, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, WB0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
